// File: rtl/fir_uart_pkg.sv
// Shared constants, coefficient table and FSM state types for the UART-fronted 8-tap FIR.
package fir_uart_pkg;

  localparam int unsigned CLK_FREQ  = 50_000_000;
  localparam int unsigned BAUD      = 115_200;
  localparam int unsigned BIT_DIV   = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int unsigned HALF_DIV  = BIT_DIV / 2;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned COEF_W    = 16;
  localparam int unsigned TAPS      = 8;
  localparam int unsigned ACC_W     = 35;
  localparam int unsigned TAP_IDX_W = $clog2(TAPS);
  // Q1.15 coefficients: the output window starts just above the fractional bits.
  localparam int unsigned OUT_LSB   = COEF_W - 1;
  localparam int unsigned OUT_MSB   = OUT_LSB + DATA_W - 1;

  typedef logic signed [COEF_W-1:0] coef_t;

  // Element [k] multiplies x[n-k].
  localparam logic [TAPS-1:0][COEF_W-1:0] COEFS = {
    16'd1024, 16'd2048, 16'd4096, 16'd9216,
    16'd9216, 16'd4096, 16'd2048, 16'd1024
  };

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

  function automatic coef_t coef_at(logic [TAP_IDX_W-1:0] idx);
    return coef_t'(COEFS[idx]);
  endfunction

endpackage

// File: rtl/fir_mac_core.sv
// Delay line plus single-MAC sequencer for the 8-tap FIR; one product per cycle.
// Define FIR_SATURATE_EN to clamp the output instead of wrapping.
module fir_mac_core
  import fir_uart_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sample_valid_i,
  input  logic [DATA_W-1:0] sample_i,
  output logic              result_valid_o,
  output logic [DATA_W-1:0] result_o
);

  localparam int unsigned StepW = TAP_IDX_W + 1;
  localparam int unsigned TopW  = ACC_W - OUT_MSB;

  logic signed [DATA_W-1:0] delay_q [TAPS];
  logic signed [DATA_W-1:0] delay_d [TAPS];
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [StepW-1:0]         step_q, step_d;
  logic                     busy_q, busy_d;
  logic [DATA_W-1:0]        result_q, result_d;
  logic                     result_valid_q, result_valid_d;

  logic [TAP_IDX_W-1:0]            tap_idx;
  logic signed [COEF_W+DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]         prod_ext;
  logic [DATA_W-1:0]               acc_out;

  assign tap_idx  = step_q[TAP_IDX_W-1:0];
  assign prod     = coef_at(tap_idx) * delay_q[tap_idx];
  assign prod_ext = ACC_W'(prod);

  always_comb begin
`ifdef FIR_SATURATE_EN
    // Bits above the output window must all match the sign, else clamp.
    if (acc_q[ACC_W-1:OUT_MSB] != {TopW{acc_q[ACC_W-1]}}) begin
      acc_out = acc_q[ACC_W-1] ? 16'h8000 : 16'h7FFF;
    end else begin
      acc_out = acc_q[OUT_MSB:OUT_LSB];
    end
`else
    acc_out = acc_q[OUT_MSB:OUT_LSB];
`endif
  end

  always_comb begin
    delay_d        = delay_q;
    acc_d          = acc_q;
    step_d         = step_q;
    busy_d         = busy_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    if (busy_q) begin
      if (step_q == StepW'(TAPS)) begin
        result_d       = acc_out;
        result_valid_d = 1'b1;
        busy_d         = 1'b0;
      end else begin
        acc_d  = acc_q + prod_ext;
        step_d = step_q + StepW'(1);
      end
    end else if (sample_valid_i) begin
      delay_d[0] = sample_i;
      for (int unsigned k = 1; k < TAPS; k++) begin
        delay_d[k] = delay_q[k-1];
      end
      acc_d  = '0;
      step_d = '0;
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < TAPS; k++) begin
        delay_q[k] <= '0;
      end
      acc_q          <= '0;
      step_q         <= '0;
      busy_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      delay_q        <= delay_d;
      acc_q          <= acc_d;
      step_q         <= step_d;
      busy_q         <= busy_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign result_valid_o = result_valid_q;
  assign result_o       = result_q;

endmodule

// File: rtl/fir_uart_top.sv
// Board top: UART 8N1 receiver -> 16-bit sample assembly -> FIR core -> UART transmitter.
// Samples and results travel high byte first.
module fir_uart_top #(
  parameter int unsigned CLK_FREQ = fir_uart_pkg::CLK_FREQ,
  parameter int unsigned BAUD     = fir_uart_pkg::BAUD
) (
  input  logic CLOCK_50,
  input  logic KEY,
  input  logic UART_RXD,
  output logic UART_TXD
);
  import fir_uart_pkg::*;

  localparam int unsigned BitDiv  = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int unsigned HalfDiv = BitDiv / 2;
  localparam int unsigned CntW    = 16;
  localparam logic [CntW-1:0] BitLast  = CntW'(BitDiv - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(HalfDiv - 1);

  // RX path state
  logic              rxd_meta_q, rxd_meta_d, rxd_sync_q, rxd_sync_d, rxd_prev_q, rxd_prev_d;
  rx_state_e         rx_state_q, rx_state_d;
  logic [CntW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic              byte_lo_q, byte_lo_d;
  logic [7:0]        hi_byte_q, hi_byte_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              sample_valid_q, sample_valid_d;

  // TX path state
  tx_state_e         tx_state_q, tx_state_d;
  logic [CntW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]        tx_bit_q, tx_bit_d;
  logic              tx_lo_q, tx_lo_d;
  logic [DATA_W-1:0] tx_word_q, tx_word_d;
  logic              pend_q, pend_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic              txd_q, txd_d;

  logic              result_valid;
  logic [DATA_W-1:0] result;
  logic [7:0]        tx_byte;
  logic [2:0]        tx_bit_nxt;

  fir_mac_core u_mac_core (
    .clk_i          (CLOCK_50),
    .rst_ni         (KEY),
    .sample_valid_i (sample_valid_q),
    .sample_i       (sample_q),
    .result_valid_o (result_valid),
    .result_o       (result)
  );

  always_comb begin
    rxd_meta_d     = UART_RXD;
    rxd_sync_d     = rxd_meta_q;
    rxd_prev_d     = rxd_sync_q;
    rx_state_d     = rx_state_q;
    rx_cnt_d       = rx_cnt_q;
    rx_bit_d       = rx_bit_q;
    rx_shift_d     = rx_shift_q;
    byte_lo_d      = byte_lo_q;
    hi_byte_d      = hi_byte_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (rxd_prev_q && !rxd_sync_q) begin
          rx_state_d = RxStart;
          rx_cnt_d   = '0;
        end
      end
      RxStart: begin
        if (rx_cnt_q == HalfLast) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rxd_sync_q ? RxIdle : RxData;
        end else begin
          rx_cnt_d = rx_cnt_q + CntW'(1);
        end
      end
      RxData: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RxStop;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CntW'(1);
        end
      end
      RxStop: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d   = '0;
          rx_state_d = RxIdle;
          // A low stop bit drops the byte and leaves the high/low toggle alone.
          if (rxd_sync_q) begin
            if (!byte_lo_q) begin
              hi_byte_d = rx_shift_q;
              byte_lo_d = 1'b1;
            end else begin
              sample_d       = {hi_byte_q, rx_shift_q};
              sample_valid_d = 1'b1;
              byte_lo_d      = 1'b0;
            end
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CntW'(1);
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  assign tx_byte    = tx_lo_q ? tx_word_q[7:0] : tx_word_q[15:8];
  assign tx_bit_nxt = tx_bit_q + 3'd1;

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_lo_d     = tx_lo_q;
    tx_word_d   = tx_word_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    txd_d       = txd_q;
    unique case (tx_state_q)
      TxIdle: begin
        txd_d = 1'b1;
        if (pend_q) begin
          tx_word_d  = pend_data_q;
          pend_d     = 1'b0;
          tx_lo_d    = 1'b0;
          tx_cnt_d   = '0;
          txd_d      = 1'b0;
          tx_state_d = TxStart;
        end
      end
      TxStart: begin
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          txd_d      = tx_byte[0];
          tx_state_d = TxData;
        end else begin
          tx_cnt_d = tx_cnt_q + CntW'(1);
        end
      end
      TxData: begin
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = TxStop;
          end else begin
            tx_bit_d = tx_bit_nxt;
            txd_d    = tx_byte[tx_bit_nxt];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CntW'(1);
        end
      end
      TxStop: begin
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d = '0;
          // Low byte follows the high byte with no idle gap.
          if (!tx_lo_q) begin
            tx_lo_d    = 1'b1;
            txd_d      = 1'b0;
            tx_state_d = TxStart;
          end else begin
            txd_d      = 1'b1;
            tx_state_d = TxIdle;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CntW'(1);
        end
      end
      default: tx_state_d = TxIdle;
    endcase
    // A newer result overwrites one still waiting to start.
    if (result_valid) begin
      pend_d      = 1'b1;
      pend_data_d = result;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!KEY) begin
      rxd_meta_q     <= 1'b1;
      rxd_sync_q     <= 1'b1;
      rxd_prev_q     <= 1'b1;
      rx_state_q     <= RxIdle;
      rx_cnt_q       <= '0;
      rx_bit_q       <= '0;
      rx_shift_q     <= '0;
      byte_lo_q      <= 1'b0;
      hi_byte_q      <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      tx_state_q     <= TxIdle;
      tx_cnt_q       <= '0;
      tx_bit_q       <= '0;
      tx_lo_q        <= 1'b0;
      tx_word_q      <= '0;
      pend_q         <= 1'b0;
      pend_data_q    <= '0;
      txd_q          <= 1'b1;
    end else begin
      rxd_meta_q     <= rxd_meta_d;
      rxd_sync_q     <= rxd_sync_d;
      rxd_prev_q     <= rxd_prev_d;
      rx_state_q     <= rx_state_d;
      rx_cnt_q       <= rx_cnt_d;
      rx_bit_q       <= rx_bit_d;
      rx_shift_q     <= rx_shift_d;
      byte_lo_q      <= byte_lo_d;
      hi_byte_q      <= hi_byte_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      tx_state_q     <= tx_state_d;
      tx_cnt_q       <= tx_cnt_d;
      tx_bit_q       <= tx_bit_d;
      tx_lo_q        <= tx_lo_d;
      tx_word_q      <= tx_word_d;
      pend_q         <= pend_d;
      pend_data_q    <= pend_data_d;
      txd_q          <= txd_d;
    end
  end

  assign UART_TXD = txd_q;

endmodule

// File: tb/tb_fir_uart_top.sv
// Scoreboard bench for fir_uart_top: drives UART samples, decodes the TX line and compares.
module tb_fir_uart_top;

  localparam int unsigned TbClkFreq = 3_200_000;
  localparam int unsigned TbBaud    = 100_000;
  localparam int unsigned BitCyc    = 32;
  localparam int unsigned HalfCyc   = 16;

  logic CLOCK_50 = 1'b0;
  logic KEY;
  logic UART_RXD;
  logic UART_TXD;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] exp_q [$];

  logic [15:0] imp_exp [8] = '{16'h0200, 16'h0400, 16'h0800, 16'h1200,
                               16'h1200, 16'h0800, 16'h0400, 16'h0200};
  logic [15:0] dc_exp  [8] = '{16'd31, 16'd93, 16'd218, 16'd500,
                               16'd781, 16'd906, 16'd968, 16'd1000};
  logic [15:0] pos_exp [8] = '{16'h03FF, 16'h0BFF, 16'h1BFF, 16'h3FFF,
                               16'h63FF, 16'h73FF, 16'h7BFF, 16'h7FFF};
  logic [15:0] neg_exp [8] = '{16'h77FF, 16'h67FF, 16'h47FF, 16'hFFFF,
                               16'hB7FF, 16'h97FF, 16'h87FF, 16'h8000};

  fir_uart_top #(
    .CLK_FREQ (TbClkFreq),
    .BAUD     (TbBaud)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .KEY      (KEY),
    .UART_RXD (UART_RXD),
    .UART_TXD (UART_TXD)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    UART_RXD = 1'b0;
    repeat (BitCyc) @(negedge CLOCK_50);
    for (int i = 0; i < 8; i++) begin
      UART_RXD = b[i];
      repeat (BitCyc) @(negedge CLOCK_50);
    end
    UART_RXD = stop_bit;
    repeat (BitCyc) @(negedge CLOCK_50);
    UART_RXD = 1'b1;
  endtask

  task automatic send_sample(input logic [15:0] x, input logic [15:0] e);
    exp_q.push_back(e);
    send_byte(x[15:8], 1'b1);
    send_byte(x[7:0], 1'b1);
  endtask

  task automatic wait_drain(input string name, input int unsigned budget);
    int unsigned i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge CLOCK_50);
      i++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // TX line decoder: runs independently and checks each completed word against the queue.
  initial begin
    int          mstate = 0;
    int          mcnt   = 0;
    int          mbit   = 0;
    logic [7:0]  mbyte  = '0;
    logic [7:0]  mhi    = '0;
    bit          mhave  = 1'b0;
    logic [15:0] word;
    logic [15:0] e;
    forever begin
      @(negedge CLOCK_50);
      if (KEY !== 1'b1) begin
        mstate = 0;
        mhave  = 1'b0;
      end else begin
        case (mstate)
          0: if (UART_TXD === 1'b0) begin
            mstate = 1;
            mcnt   = HalfCyc;
          end
          1: begin
            mcnt--;
            if (mcnt == 0) begin
              check("tx_start_bit", UART_TXD, 0);
              mstate = 2;
              mcnt   = BitCyc;
              mbit   = 0;
            end
          end
          2: begin
            mcnt--;
            if (mcnt == 0) begin
              mbyte[mbit] = UART_TXD;
              mbit++;
              mcnt = BitCyc;
              if (mbit == 8) mstate = 3;
            end
          end
          default: begin
            mcnt--;
            if (mcnt == 0) begin
              check("tx_stop_bit", UART_TXD, 1);
              mstate = 0;
              if (!mhave) begin
                mhi   = mbyte;
                mhave = 1'b1;
              end else begin
                mhave = 1'b0;
                word  = {mhi, mbyte};
                if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL tx_unexpected: got 0x%04h, required no frame", word);
                end else begin
                  e = exp_q.pop_front();
                  check("tx_word", word, e);
                end
              end
            end
          end
        endcase
      end
    end
  end

  initial begin
    repeat (90000) @(posedge CLOCK_50);
    $display("FAIL watchdog: got no completion, required finish within 90000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit quiet;
    bit got;
    KEY      = 1'b0;
    UART_RXD = 1'b1;

    // Reset held two cycles, then idle line.
    @(posedge CLOCK_50); #1;
    check("reset_txd_c1", UART_TXD, 1);
    @(posedge CLOCK_50); #1;
    check("reset_txd_c2", UART_TXD, 1);
    @(negedge CLOCK_50);
    KEY   = 1'b1;
    quiet = 1'b1;
    repeat (3 * BitCyc) begin
      @(negedge CLOCK_50);
      if (UART_TXD !== 1'b1) quiet = 1'b0;
    end
    check("idle_txd_high", quiet, 1);

    for (int i = 0; i < 8; i++) send_sample((i == 0) ? 16'h4000 : 16'h0000, imp_exp[i]);
    for (int i = 0; i < 8; i++) send_sample(16'h03E8, dc_exp[i]);

    // Byte with a low stop bit must be dropped; history is then 1000 x7.
    send_byte(8'hAA, 1'b0);
    repeat (2 * BitCyc) @(negedge CLOCK_50);
    send_sample(16'h0010, 16'h03C9);

    wait_drain("drain_before_reset", 60 * BitCyc);
    repeat (2 * BitCyc) @(negedge CLOCK_50);

    // Result of this sample is 0x038B; abort it during data bit 4 of the high byte (a 0).
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 4 * BitCyc && !got; i++) begin
      @(negedge CLOCK_50);
      if (UART_TXD === 1'b0) got = 1'b1;
    end
    check("rst_tx_started", got, 1);
    repeat (5 * BitCyc + HalfCyc) @(negedge CLOCK_50);
    check("rst_pre_txd_low", UART_TXD, 0);
    KEY = 1'b0;
    @(posedge CLOCK_50); #1;
    check("rst_txd_next_clk", UART_TXD, 1);
    @(negedge CLOCK_50);
    KEY   = 1'b1;
    quiet = 1'b1;
    repeat (3 * BitCyc) begin
      @(negedge CLOCK_50);
      if (UART_TXD !== 1'b1) quiet = 1'b0;
    end
    check("rst_tx_abandoned", quiet, 1);

    // Zero history after reset: first 0x7FFF must give the n=0 partial sum.
    for (int i = 0; i < 8; i++) send_sample(16'h7FFF, pos_exp[i]);
    for (int i = 0; i < 8; i++) send_sample(16'h8000, neg_exp[i]);
    send_sample(16'h7FFF, 16'h87FF);
    send_sample(16'h8000, 16'h8FFF);

    wait_drain("drain_final", 60 * BitCyc);
    repeat (2 * BitCyc) @(negedge CLOCK_50);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
